serial_alu_sequencer: RTL and testbench

- Bit-serial controller that drives a single 1-bit arithmetic segment (full adder plus 4:1 B-select mux) through a WIDTH-bit operation, one bit per clock, LSB first.
- Sits directly upstream of the segment: supplies its A, B, Cin and S inputs, and consumes its D and Cout outputs.
- Assembles the result word, holds a carry flag across operations (used for multi-precision ADC/SBB), and produces status flags.

---
 rtl/serial_alu_sequencer.sv | 163 ++++++++++++++++
 tb/tb_serial_alu_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/serial_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : serial_alu_sequencer
// Brief    : Bit-serial controller for a 1-bit adder/B-select segment;
//            assembles a WIDTH-bit result LSB first and maintains CF/ZF/NF/VF.
// Revision : 1.0 - initial release
// ============================================================================
module serial_alu_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             seg_a,
    output logic             seg_b,
    output logic             seg_cin,
    output logic [1:0]       seg_s,
    input  logic             seg_d,
    input  logic             seg_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_o,
    output logic             cf_o,
    output logic             zf_o,
    output logic             nf_o,
    output logic             vf_o
);

    localparam int                CNT_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  c_LAST = CNT_W'(WIDTH - 1);

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_ADC = 3'b001;
    localparam logic [2:0] c_OP_SUB = 3'b010;
    localparam logic [2:0] c_OP_SBB = 3'b011;
    localparam logic [2:0] c_OP_TFA = 3'b100;
    localparam logic [2:0] c_OP_INC = 3'b101;
    localparam logic [2:0] c_OP_DEC = 3'b110;
    localparam logic [2:0] c_OP_CMP = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [2:0]       r_op;
    logic             r_cin0;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             w_cin0;
    logic [1:0]       w_sel;
    logic [WIDTH-1:0] w_word;

    // Bit-0 carry-in chosen from the incoming op at start time
    always_comb begin
        w_cin0 = 1'b0;
        case (op)
            c_OP_ADC, c_OP_SBB:           w_cin0 = cf_o;
            c_OP_SUB, c_OP_CMP, c_OP_INC: w_cin0 = 1'b1;
            default:                      w_cin0 = 1'b0;
        endcase
    end

    always_comb begin
        w_sel = 2'b00;
        case (r_op)
            c_OP_ADD, c_OP_ADC:           w_sel = 2'b00;
            c_OP_SUB, c_OP_SBB, c_OP_CMP: w_sel = 2'b01;
            c_OP_TFA, c_OP_INC:           w_sel = 2'b10;
            c_OP_DEC:                     w_sel = 2'b11;
            default:                      w_sel = 2'b00;
        endcase
    end

    assign w_word = {seg_d, r_res[WIDTH-1:1]};

    always_comb begin
        w_next_state = r_state;
        seg_a        = 1'b0;
        seg_b        = 1'b0;
        seg_cin      = 1'b0;
        seg_s        = 2'b00;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next_state = S_RUN;
            end
            S_RUN: begin
                busy    = 1'b1;
                seg_a   = r_a[0];
                seg_b   = r_b[0];
                seg_s   = w_sel;
                seg_cin = (r_cnt == '0) ? r_cin0 : r_carry;
                if (r_cnt == c_LAST) w_next_state = S_DONE;
            end
            S_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_op     <= '0;
            r_cin0   <= 1'b0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            result_o <= '0;
            cf_o     <= 1'b0;
            zf_o     <= 1'b0;
            nf_o     <= 1'b0;
            vf_o     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a    <= a_i;
                        r_b    <= b_i;
                        r_op   <= op;
                        r_cin0 <= w_cin0;
                        r_cnt  <= '0;
                    end
                end
                S_RUN: begin
                    r_res   <= w_word;
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= seg_cout;
                    r_cnt   <= r_cnt + 1'b1;
                    // Last bit: seg_cin is the carry into the MSB, seg_cout the final carry
                    if (r_cnt == c_LAST) begin
                        if (r_op != c_OP_CMP) result_o <= w_word;
                        cf_o <= seg_cout;
                        zf_o <= (w_word == '0);
                        nf_o <= seg_d;
                        vf_o <= seg_cin ^ seg_cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_alu_sequencer
// Brief    : Directed vector bench for serial_alu_sequencer with a 1-bit
//            segment model attached to the seg_* interface.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_alu_sequencer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a_i, b_i;
    logic         seg_a, seg_b, seg_cin, seg_d, seg_cout;
    logic [1:0]   seg_s;
    logic         busy, done, cf_o, zf_o, nf_o, vf_o;
    logic [W-1:0] result_o;
    logic         w_bs;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // The arithmetic segment: B-select mux feeding a full adder
    always_comb begin
        case (seg_s)
            2'b00:   w_bs = seg_b;
            2'b01:   w_bs = ~seg_b;
            2'b10:   w_bs = 1'b0;
            default: w_bs = 1'b1;
        endcase
    end
    assign seg_d    = seg_a ^ w_bs ^ seg_cin;
    assign seg_cout = (seg_a & w_bs) | (seg_a & seg_cin) | (w_bs & seg_cin);

    serial_alu_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a_i(a_i), .b_i(b_i),
        .seg_a(seg_a), .seg_b(seg_b), .seg_cin(seg_cin), .seg_s(seg_s),
        .seg_d(seg_d), .seg_cout(seg_cout), .busy(busy), .done(done),
        .result_o(result_o), .cf_o(cf_o), .zf_o(zf_o), .nf_o(nf_o), .vf_o(vf_o)
    );

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a, b, res;
        logic         cf, zf, nf, vf;
        logic [1:0]   s;
        logic         cin0;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, id, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        op    = o;
        a_i   = a;
        b_i   = b;
        tick();
        start = 1'b0;
    endtask

    task automatic run_check(input vec_t v, input int id);
        int         n, busy_n;
        logic [1:0] s0;
        logic       cin0, s_stable;
        issue(v.op, v.a, v.b);
        n = 0; busy_n = 0; s_stable = 1'b1;
        s0 = seg_s; cin0 = seg_cin;
        while (!done && n < 4 * W) begin
            if (busy) busy_n++;
            if (seg_s !== s0) s_stable = 1'b0;
            tick();
            n++;
        end
        if (busy) busy_n++;
        chk("latency", id, n, W);
        chk("busy_cycles", id, busy_n, W + 1);
        chk("seg_s", id, s0, v.s);
        chk("seg_s_stable", id, s_stable, 1);
        chk("cin0", id, cin0, v.cin0);
        chk("result", id, result_o, v.res);
        chk("flags", id, {cf_o, zf_o, nf_o, vf_o}, {v.cf, v.zf, v.nf, v.vf});
        tick();
        chk("done_width", id, {busy, done}, 2'b00);
    endtask

    initial begin
        int   dcnt;
        logic [W-1:0] seen;
        vecs[0]  = '{3'b000, 8'h3C, 8'h0F, 8'h4B, 0, 0, 0, 0, 2'b00, 0}; // ADD
        vecs[1]  = '{3'b000, 8'h7F, 8'h01, 8'h80, 0, 0, 1, 1, 2'b00, 0}; // ADD signed overflow
        vecs[2]  = '{3'b000, 8'hFF, 8'h01, 8'h00, 1, 1, 0, 0, 2'b00, 0}; // ADD wrap
        vecs[3]  = '{3'b001, 8'h10, 8'h20, 8'h31, 0, 0, 0, 0, 2'b00, 1}; // ADC cf=1
        vecs[4]  = '{3'b010, 8'h05, 8'h07, 8'hFE, 0, 0, 1, 0, 2'b01, 1}; // SUB borrow
        vecs[5]  = '{3'b010, 8'h07, 8'h05, 8'h02, 1, 0, 0, 0, 2'b01, 1}; // SUB no borrow
        vecs[6]  = '{3'b110, 8'h00, 8'h00, 8'hFF, 0, 0, 1, 0, 2'b11, 0}; // DEC
        vecs[7]  = '{3'b101, 8'hFF, 8'h00, 8'h00, 1, 1, 0, 0, 2'b10, 1}; // INC
        vecs[8]  = '{3'b111, 8'h42, 8'h42, 8'h00, 1, 1, 0, 0, 2'b01, 1}; // CMP keeps result
        vecs[9]  = '{3'b011, 8'h10, 8'h05, 8'h0B, 1, 0, 0, 0, 2'b01, 1}; // SBB cf=1
        vecs[10] = '{3'b100, 8'h9A, 8'h55, 8'h9A, 0, 0, 1, 0, 2'b10, 0}; // TFA

        rst_n = 1'b0; start = 1'b0; op = 3'b000; a_i = 8'hFF; b_i = 8'hFF;
        tick(); tick();
        chk("rst_status", 0, {busy, done}, 2'b00);
        chk("rst_result", 0, result_o, 0);
        chk("rst_flags", 0, {cf_o, zf_o, nf_o, vf_o}, 4'b0000);
        chk("rst_seg", 0, {seg_a, seg_b, seg_cin, seg_s}, 5'b00000);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) run_check(vecs[i], i);

        // start re-pulsed in RUN cycle 3 must be ignored
        issue(3'b000, 8'h01, 8'h01);
        tick(); tick();
        start = 1'b1; op = 3'b010; a_i = 8'hFF; b_i = 8'hFF;
        tick();
        start = 1'b0;
        dcnt = 0; seen = '0;
        for (int k = 0; k < 20; k++) begin
            if (done) begin
                dcnt++;
                seen = result_o;
            end
            tick();
        end
        chk("ignore_done_cnt", 0, dcnt, 1);
        chk("ignore_result", 0, seen, 8'h02);
        chk("ignore_idle", 0, busy, 0);

        // reset mid-operation clears everything, carry included
        run_check('{3'b000, 8'hFF, 8'h01, 8'h00, 1, 1, 0, 0, 2'b00, 0}, 20);
        issue(3'b000, 8'h01, 8'h01);
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        chk("abort_status", 0, {busy, done}, 2'b00);
        chk("abort_result", 0, result_o, 0);
        chk("abort_flags", 0, {cf_o, zf_o, nf_o, vf_o}, 4'b0000);
        rst_n = 1'b1;
        tick();
        run_check('{3'b001, 8'h01, 8'h01, 8'h02, 0, 0, 0, 0, 2'b00, 0}, 21);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
